// File: rtl/roxxon_pkg.sv
// Shared definitions for the instruction sequencer and the SIMD Control_Unit:
// sequencer state encoding, halt-bit position and opcode constants.
package roxxon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_HALT      = 3'd4
  } seq_state_t;

  // Bit of an instruction word that marks it as a halt word.
  localparam int HALT_BIT = 7;

  // Opcodes understood by the Control_Unit.
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_LOAD  = 8'h01;
  localparam logic [7:0] OP_STORE = 8'h02;
  localparam logic [7:0] OP_ADD   = 8'h03;
  localparam logic [7:0] OP_SUB   = 8'h04;
  localparam logic [7:0] OP_MUL   = 8'h05;
  localparam logic [7:0] OP_AND   = 8'h06;
  localparam logic [7:0] OP_OR    = 8'h07;
  localparam logic [7:0] OP_XOR   = 8'h08;
  localparam logic [7:0] OP_SHL   = 8'h09;
  localparam logic [7:0] OP_SHR   = 8'h0A;
  localparam logic [7:0] OP_HALT  = 8'h80;

  // True when the low byte of a fetched word requests a halt.
  function automatic logic is_halt_word(input logic [7:0] opc);
    return opc[HALT_BIT];
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Program RAM for the instruction sequencer: single port, write-first,
// synchronous read. Contents are deliberately not reset so a program
// survives a sequencer reset.
module instr_mem #(
  parameter int IW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [IW-1:0] wdata,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem_r [DEPTH];
  logic [IW-1:0] rdata_r;

  // Write-first port: a write also returns the written word on the read data.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem_r[addr] <= wdata;
      rdata_r     <= wdata;
    end else begin
      rdata_r     <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction issuer for the SIMD Control_Unit. Fetches program words in
// order, presents each on INSTR with ONSWT high until DONE, and pulses
// OFFSWT on a halt word, on running past the last entry, or on timeout.
// Optional feature: define SEQ_TIMEOUT_EN to build the DONE-wait watchdog.
module instr_sequencer
  import roxxon_pkg::*;
#(
  parameter int IW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
`ifdef SEQ_TIMEOUT_EN
  ,
  parameter int TMO   = 256
`endif
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          PROG_WE,
  input  logic [AW-1:0] PROG_ADDR,
  input  logic [IW-1:0] PROG_DATA,
  input  logic          START,
  input  logic          DONE,
  output logic [IW-1:0] INSTR,
  output logic          ONSWT,
  output logic          OFFSWT,
  output logic [AW-1:0] PC,
  output logic          BUSY,
  output logic          OVERRUN,
  output logic          TIMEOUT
);

  seq_state_t    state_r, state_s;
  logic [IW-1:0] instr_r, instr_s;
  logic          onswt_r, onswt_s;
  logic          offswt_r, offswt_s;
  logic [AW-1:0] pc_r, pc_s;
  logic          busy_r, busy_s;
  logic          overrun_r, overrun_s;
  logic          timeout_r, timeout_s;

  logic          mem_we_s;
  logic [AW-1:0] mem_addr_s;
  logic [IW-1:0] rdata_s;
  logic          tmo_expired_s;

  // Host writes reach the RAM only while idle; otherwise the port reads PC.
  assign mem_we_s   = RSTN && PROG_WE && (state_r == ST_IDLE);
  assign mem_addr_s = mem_we_s ? PROG_ADDR : pc_r;

  instr_mem #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .CLK   (CLK),
    .we    (mem_we_s),
    .addr  (mem_addr_s),
    .wdata (PROG_DATA),
    .rdata (rdata_s)
  );

`ifdef SEQ_TIMEOUT_EN
  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  logic [CW-1:0] tmo_cnt_r;

  // Watchdog counts cycles spent in WAIT_DONE; zero on every entry.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      tmo_cnt_r <= {CW{1'b0}};
    end else if (state_r != ST_WAIT_DONE) begin
      tmo_cnt_r <= {CW{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + CW'(1);
    end
  end

  assign tmo_expired_s = (state_r == ST_WAIT_DONE) && (tmo_cnt_r == CW'(TMO - 1));
`else
  assign tmo_expired_s = 1'b0;
`endif

  // Next-state and next-output logic; every register holds unless changed.
  always_comb begin
    state_s   = state_r;
    instr_s   = instr_r;
    onswt_s   = onswt_r;
    pc_s      = pc_r;
    overrun_s = overrun_r;
    timeout_s = timeout_r;
    case (state_r)
      ST_IDLE: begin
        if (START) begin
          state_s   = ST_FETCH;
          pc_s      = {AW{1'b0}};
          overrun_s = 1'b0;
          timeout_s = 1'b0;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (is_halt_word(rdata_s[7:0])) begin
          state_s = ST_HALT;
        end else begin
          instr_s = rdata_s;
          onswt_s = 1'b1;
          state_s = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (DONE) begin
          onswt_s = 1'b0;
          if (pc_r == AW'(DEPTH - 1)) begin
            overrun_s = 1'b1;
            state_s   = ST_HALT;
          end else begin
            pc_s      = pc_r + AW'(1);
            state_s   = ST_FETCH;
          end
        end else if (tmo_expired_s) begin
          timeout_s = 1'b1;
          onswt_s   = 1'b0;
          state_s   = ST_HALT;
        end else begin
          state_s   = ST_WAIT_DONE;
        end
      end
      ST_HALT: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        onswt_s = 1'b0;
      end
    endcase
    offswt_s = (state_s == ST_HALT);
    busy_s   = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_r   <= ST_IDLE;
      instr_r   <= {IW{1'b0}};
      onswt_r   <= 1'b0;
      offswt_r  <= 1'b0;
      pc_r      <= {AW{1'b0}};
      busy_r    <= 1'b0;
      overrun_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      instr_r   <= instr_s;
      onswt_r   <= onswt_s;
      offswt_r  <= offswt_s;
      pc_r      <= pc_s;
      busy_r    <= busy_s;
      overrun_r <= overrun_s;
      timeout_r <= timeout_s;
    end
  end

  assign INSTR   = instr_r;
  assign ONSWT   = onswt_r;
  assign OFFSWT  = offswt_r;
  assign PC      = pc_r;
  assign BUSY    = busy_r;
  assign OVERRUN = overrun_r;
  assign TIMEOUT = timeout_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a latency-counting reference model
// of the sequencer is compared against every output on every falling edge,
// with directed scenarios pinned by literal expectations and a randomized phase.
module tb_instr_sequencer;

  localparam int IW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
`ifdef SEQ_TIMEOUT_EN
  localparam int TMO   = 8;
`endif

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic          PROG_WE = 1'b0;
  logic [AW-1:0] PROG_ADDR = '0;
  logic [IW-1:0] PROG_DATA = '0;
  logic          START = 1'b0;
  logic          DONE = 1'b0;
  logic [IW-1:0] INSTR;
  logic          ONSWT, OFFSWT, BUSY, OVERRUN, TIMEOUT;
  logic [AW-1:0] PC;

  instr_sequencer #(
    .IW(IW), .DEPTH(DEPTH), .AW(AW)
`ifdef SEQ_TIMEOUT_EN
    , .TMO(TMO)
`endif
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .PROG_WE(PROG_WE), .PROG_ADDR(PROG_ADDR),
    .PROG_DATA(PROG_DATA), .START(START), .DONE(DONE), .INSTR(INSTR),
    .ONSWT(ONSWT), .OFFSWT(OFFSWT), .PC(PC), .BUSY(BUSY),
    .OVERRUN(OVERRUN), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The program is executed as: after START or an accepted DONE, the word at
  // the current PC is evaluated two edges later; it is then either presented
  // (and waits for DONE) or it is a halt word (one OFFSWT cycle, then idle).
  logic [IW-1:0] prog [DEPTH];
  logic [IW-1:0] m_instr = '0;
  logic [IW-1:0] mw;
  bit m_onswt = 0, m_offswt = 0, m_busy = 0, m_ovr = 0, m_tmo = 0;
  int m_pc = 0;
  int lat = 0;
  int wcnt = 0;

  always @(posedge CLK) begin
    if (!RSTN) begin
      m_instr = '0; m_onswt = 0; m_offswt = 0; m_busy = 0;
      m_ovr = 0; m_tmo = 0; m_pc = 0; lat = 0; wcnt = 0;
    end else if (m_offswt) begin
      m_offswt = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (PROG_WE) prog[PROG_ADDR] = PROG_DATA;
      if (START) begin
        m_busy = 1; m_pc = 0; m_ovr = 0; m_tmo = 0; lat = 2;
      end
    end else if (lat > 0) begin
      if (lat == 1) begin
        mw = prog[m_pc];
        if (mw[7]) m_offswt = 1;
        else begin
          m_instr = mw; m_onswt = 1; wcnt = 0;
        end
      end
      lat--;
    end else begin
      if (DONE) begin
        m_onswt = 0;
        if (m_pc == DEPTH - 1) begin
          m_ovr = 1; m_offswt = 1;
        end else begin
          m_pc++; lat = 2;
        end
      end
`ifdef SEQ_TIMEOUT_EN
      else if (wcnt == TMO - 1) begin
        m_tmo = 1; m_onswt = 0; m_offswt = 1;
      end else begin
        wcnt++;
      end
`endif
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge CLK) begin
    if (chk_on) begin
      check("INSTR", INSTR, m_instr);
      check("ONSWT", 32'(ONSWT), 32'(m_onswt));
      check("OFFSWT", 32'(OFFSWT), 32'(m_offswt));
      check("PC", 32'(PC), m_pc);
      check("BUSY", 32'(BUSY), 32'(m_busy));
      check("OVERRUN", 32'(OVERRUN), 32'(m_ovr));
      check("TIMEOUT", 32'(TIMEOUT), 32'(m_tmo));
    end
  end

  // ---------------- Control_Unit stand-in ----------------
  bit ack_en = 1'b1;
  bit noise_en = 1'b0;
  int ack_delay = 2;
  int ack_cnt = 0;
  int cur_delay = 2;

  always @(negedge CLK) begin
    if (DONE) begin
      DONE = 1'b0;
      ack_cnt = 0;
    end else if (ack_en && ONSWT === 1'b1) begin
      if (ack_cnt == 0) cur_delay = (ack_delay > 0) ? ack_delay : int'($urandom_range(1, 4));
      ack_cnt++;
      if (ack_cnt >= cur_delay) DONE = 1'b1;
    end else begin
      ack_cnt = 0;
      if (noise_en && ONSWT !== 1'b1) DONE = ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------- issue monitor ----------------
  logic [31:0] iss_instr[$];
  logic [31:0] iss_pc[$];
  int off_cnt = 0;
  logic onswt_q = 1'b0;

  always @(negedge CLK) begin
    if (ONSWT === 1'b1 && onswt_q !== 1'b1) begin
      iss_instr.push_back(INSTR);
      iss_pc.push_back(32'(PC));
    end
    if (OFFSWT === 1'b1) off_cnt++;
    onswt_q = ONSWT;
  end

  // ---------------- stimulus helpers (entered and left at a falling edge) ----------------
  task automatic load(input int a, input logic [31:0] d);
    PROG_WE = 1'b1; PROG_ADDR = a[AW-1:0]; PROG_DATA = d;
    @(negedge CLK);
    PROG_WE = 1'b0;
  endtask

  task automatic start_run();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic clear_mon();
    iss_instr.delete(); iss_pc.delete(); off_cnt = 0;
  endtask

  task automatic wait_idle(input int max, input string name);
    int n = 0;
    while (BUSY !== 1'b0 && n < max) begin @(negedge CLK); n++; end
    check(name, 32'(BUSY), 32'h0);
  endtask

  task automatic wait_onswt(input int max, input string name);
    int n = 0;
    while (ONSWT !== 1'b1 && n < max) begin @(negedge CLK); n++; end
    check(name, 32'(ONSWT), 32'h1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    chk_on = 1'b1;
    check("rst_instr", INSTR, 32'h0);
    check("rst_onswt", 32'(ONSWT), 32'h0);
    check("rst_pc", 32'(PC), 32'h0);
    check("rst_busy", 32'(BUSY), 32'h0);
    RSTN = 1'b1;
    for (int i = 0; i < DEPTH; i++) load(i, 32'h80);

    // 1: short program ending in a halt word
    load(0, 32'h01); load(1, 32'h09); load(2, 32'h02); load(3, 32'h80);
    clear_mon(); ack_delay = 2;
    start_run();
    wait_idle(100, "t1_idle");
    check("t1_count", iss_instr.size(), 32'd3);
    check("t1_i0", iss_instr[0], 32'h01);
    check("t1_i1", iss_instr[1], 32'h09);
    check("t1_i2", iss_instr[2], 32'h02);
    check("t1_pc2", iss_pc[2], 32'd2);
    check("t1_off", off_cnt, 32'd1);
    check("t1_ovr", 32'(OVERRUN), 32'h0);

    // 2: DONE withheld, presented word must stay put
    load(0, 32'h0A); load(1, 32'h80);
    ack_en = 1'b0;
    start_run();
    wait_onswt(10, "t2_on");
    repeat (10) begin
      @(negedge CLK);
      check("t2_instr", INSTR, 32'h0A);
      check("t2_onswt", 32'(ONSWT), 32'h1);
      check("t2_pc", 32'(PC), 32'h0);
    end
    ack_en = 1'b1;
    wait_idle(50, "t2_idle");

    // 3: no halt word, run off the end
    for (int i = 0; i < DEPTH; i++) load(i, 32'h03);
    clear_mon(); ack_delay = 0;
    start_run();
    wait_idle(400, "t3_idle");
    check("t3_ovr", 32'(OVERRUN), 32'h1);
    check("t3_count", iss_instr.size(), 32'd32);
    check("t3_lastpc", iss_pc[31], 32'd31);
    check("t3_off", off_cnt, 32'd1);

    // 4: reset in WAIT_DONE at PC=5, RAM retained
    for (int i = 0; i < DEPTH; i++) load(i, (i < 6) ? 32'h10 + 32'(i) : 32'h80);
    ack_delay = 2;
    start_run();
    begin
      int n = 0;
      while (!(ONSWT === 1'b1 && PC === 5'd5) && n < 200) begin @(negedge CLK); n++; end
    end
    check("t4_reach_pc", 32'(PC), 32'd5);
    RSTN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    check("t4_instr", INSTR, 32'h0);
    check("t4_onswt", 32'(ONSWT), 32'h0);
    check("t4_pc", 32'(PC), 32'h0);
    check("t4_busy", 32'(BUSY), 32'h0);
    clear_mon();
    start_run();
    wait_onswt(10, "t4_on");
    check("t4_first", INSTR, 32'h10);
    wait_idle(200, "t4_idle");

    // 5: writes and START while busy are dropped
    load(0, 32'h04); load(1, 32'h05); load(2, 32'h80);
    clear_mon();
    start_run();
    repeat (30) begin
      if (BUSY === 1'b1) begin
        START = 1'($urandom_range(0, 1));
        PROG_WE = 1'($urandom_range(0, 1)); PROG_ADDR = '0; PROG_DATA = 32'h80;
      end
      @(negedge CLK);
      START = 1'b0; PROG_WE = 1'b0;
    end
    wait_idle(100, "t5_idle");
    check("t5_count", iss_instr.size(), 32'd2);
    check("t5_off", off_cnt, 32'd1);
    clear_mon();
    start_run();
    wait_onswt(10, "t5_on");
    check("t5_ram0", INSTR, 32'h04);
    wait_idle(100, "t5_idle2");

`ifdef SEQ_TIMEOUT_EN
    // 6: watchdog expiry and DONE on the last allowed cycle
    load(0, 32'h0A); load(1, 32'h80);
    ack_en = 1'b0; clear_mon();
    start_run();
    wait_idle(50, "t6_idle");
    check("t6_tmo", 32'(TIMEOUT), 32'h1);
    check("t6_off", off_cnt, 32'd1);
    ack_en = 1'b1; ack_delay = 8;
    start_run();
    wait_idle(50, "t6b_idle");
    check("t6b_tmo", 32'(TIMEOUT), 32'h0);
    ack_delay = 2;
`endif

    // Randomized runs with spurious DONE, blocked writes/starts and resets
    noise_en = 1'b1; ack_delay = 0;
    repeat (25) begin
      for (int i = 1; i < DEPTH; i++) begin
        logic [31:0] w;
        w = $urandom;
        w[7] = ($urandom_range(0, 9) == 0);
        load(i, w);
      end
      begin
        logic [31:0] w0;
        w0 = $urandom;
        w0[7] = 1'b0;
        PROG_WE = 1'b1; PROG_ADDR = '0; PROG_DATA = w0; START = 1'b1;
        @(negedge CLK);
        PROG_WE = 1'b0; START = 1'b0;
      end
      begin
        int n = 0;
        while (BUSY === 1'b1 && n < 1000) begin
          START = ($urandom_range(0, 7) == 0);
          PROG_WE = ($urandom_range(0, 7) == 0);
          PROG_ADDR = AW'($urandom_range(0, DEPTH - 1));
          PROG_DATA = $urandom;
          RSTN = ($urandom_range(0, 199) != 0);
          @(negedge CLK);
          START = 1'b0; PROG_WE = 1'b0; RSTN = 1'b1;
          n++;
        end
      end
      wait_idle(20, "rnd_idle");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
